// File: rtl/instr_queue.sv
// -----------------------------------------------------------------------------
// instr_queue
//
// Circular FIFO between the control unit and the execution back end. One
// decoded entry may be pushed per cycle; the oldest POP_WIDTH entries are
// exposed every cycle and 0..POP_WIDTH of them are retired per cycle.
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   queue_we            - push strobe
//   queue_instr_type    - 2-bit type of the pushed entry
//   queue_instr         - 16-bit raw instruction of the pushed entry
//   cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr
//                       - 18-bit address fields of the pushed entry
//   pop_count           - number of entries retired this cycle
//   out_valid           - bit i set when read slot i holds a valid entry
//   out_entry           - slot i at [i*90 +: 90], fields from MSB:
//                         type, instr, cache, main_mem, d_cache, d_main_mem
//   count               - current occupancy
//   full, almost_full   - back-pressure, combinational from count
//   overflow, underflow - sticky error flags, cleared only by reset
// -----------------------------------------------------------------------------
module instr_queue #(
    parameter int LOG_DEPTH          = 4,
    parameter int POP_WIDTH          = 3,
    parameter int ALMOST_FULL_MARGIN = 2,
    localparam int ENTRY_W           = 90,
    localparam int PCW               = $clog2(POP_WIDTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         queue_we,
    input  logic [1:0]                   queue_instr_type,
    input  logic [15:0]                  queue_instr,
    input  logic [17:0]                  cache_addr,
    input  logic [17:0]                  main_mem_addr,
    input  logic [17:0]                  d_cache_addr,
    input  logic [17:0]                  d_main_mem_addr,
    input  logic [PCW-1:0]               pop_count,
    output logic [POP_WIDTH-1:0]         out_valid,
    output logic [POP_WIDTH*ENTRY_W-1:0] out_entry,
    output logic [LOG_DEPTH:0]           count,
    output logic                         full,
    output logic                         almost_full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int CW    = LOG_DEPTH + 1;

    logic [ENTRY_W-1:0]   storage_q [DEPTH];
    logic [ENTRY_W-1:0]   storage_d [DEPTH];
    logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;

    logic [ENTRY_W-1:0]   push_entry;
    logic [CW-1:0]        pop_ext;
    logic [CW-1:0]        eff_pop;
    logic [CW-1:0]        free_entries;
    logic                 push_ok;

    assign push_entry = {queue_instr_type, queue_instr, cache_addr,
                         main_mem_addr, d_cache_addr, d_main_mem_addr};

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        pop_ext     = CW'(pop_count);
        // Never retire more than is actually held.
        eff_pop     = (pop_ext > count_q) ? count_q : pop_ext;
        underflow_d = underflow_q | (pop_ext > count_q);

        // A full queue still accepts a push when at least one entry leaves.
        push_ok     = queue_we && ((count_q - eff_pop) < CW'(DEPTH));
        overflow_d  = overflow_q | (queue_we & ~push_ok);

        storage_d   = storage_q;
        wr_ptr_d    = wr_ptr_q;
        if (push_ok) begin
            storage_d[wr_ptr_q] = push_entry;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end

        // Truncation gives the modulo-DEPTH wrap, including eff_pop == DEPTH.
        rd_ptr_d = rd_ptr_q + eff_pop[LOG_DEPTH-1:0];
        count_d  = count_q + CW'(push_ok) - eff_pop;
    end

    // NOTE: storage is reset along with the pointers because the read slots
    // must present all-zero data while the queue is held in reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            storage_q   <= storage_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Read slots: no bypass, so only registered storage is ever exposed.
    always_comb begin
        out_valid = '0;
        out_entry = '0;
        for (int i = 0; i < POP_WIDTH; i++) begin
            out_valid[i]                    = (count_q > CW'(i));
            out_entry[i*ENTRY_W +: ENTRY_W] = storage_q[rd_ptr_q + LOG_DEPTH'(i)];
        end
    end

    assign free_entries = CW'(DEPTH) - count_q;
    assign count        = count_q;
    assign full         = (count_q == CW'(DEPTH));
    assign almost_full  = (int'(free_entries) <= ALMOST_FULL_MARGIN);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
